// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-aware round-robin arbiter driving one registered FIFO write port.
// Optional feature: define ARB_BURST_LIMIT_EN to release a grant after MAX_BURST beats.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DW        = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    input  logic [NUM_REQ*DW-1:0]      req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       fifo_wr_en,
    output logic [DW-1:0]              fifo_data_in,
    input  logic                       fifo_full,
    input  logic                       fifo_almost_full,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   next_ptr;
    logic [CW-1:0]   beat_cnt;
    logic [CW-1:0]   beat_cnt_inc;
    logic [DW-1:0]   grant_data;
    logic            found;
    logic            accept;
    logic            acc_last;
    logic            burst_done;
    logic            release_grant;

    // Round-robin search: first valid index at or above rr_ptr, wrapping explicitly
    // so non-power-of-two NUM_REQ never selects a nonexistent requester.
    always_comb begin
        int            idx;
        logic [IW-1:0] sel;
        // NOTE: every combinational output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = IW'(idx);
            if (!found && req_valid[sel]) begin
                found = 1'b1;
                pick  = sel;
            end
        end
    end

    // Ready drops in the same cycle almost_full rises; full is gated as a safety net.
    always_comb begin
        req_ready = '0;
        if (state == GRANT && !fifo_full && !fifo_almost_full) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IW'(i)) begin
                grant_data = req_data[i*DW +: DW];
            end
        end
    end

    assign accept       = |(req_valid & req_ready);
    assign acc_last     = |(req_valid & req_ready & req_last);
    assign beat_cnt_inc = beat_cnt + 1'b1;
    assign next_ptr     = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;

`ifdef ARB_BURST_LIMIT_EN
    assign burst_done = (beat_cnt_inc == BURST_MAX);
`else
    assign burst_done = 1'b0;
`endif

    assign release_grant = accept && (acc_last || burst_done);
    assign busy          = (state == GRANT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found)         state_nxt = GRANT;
            GRANT:   if (release_grant) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all registered state below uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            beat_cnt     <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
        end else begin
            state      <= state_nxt;
            fifo_wr_en <= accept;
            if (accept) begin
                fifo_data_in <= grant_data;
            end
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id <= pick;
                        beat_cnt <= '0;
                    end
                end
                GRANT: begin
                    // Saturates so the count never wraps on long packets.
                    if (accept && beat_cnt != BURST_MAX) begin
                        beat_cnt <= beat_cnt_inc;
                    end
                    if (release_grant) begin
                        rr_ptr <= next_ptr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench for fifo_wr_arbiter; expected FIFO writes are
// queued when packets are loaded and compared as writes emerge.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_last;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_data_in;
    logic              fifo_full;
    logic              fifo_almost_full;
    logic [1:0]        grant_id;
    logic              busy;

    fifo_wr_arbiter #(.NUM_REQ(N), .DW(DW), .MAX_BURST(MB)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_last         (req_last),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_data_in     (fifo_data_in),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .grant_id         (grant_id),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] pkt_data [N][$];
    logic          pkt_last [N][$];
    logic [DW-1:0] exp_q [$];
    int            acc_q [$];
    int            wr_cycles [$];
    int            acc_cnt [N];
    logic [N-1:0]  last_acc;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int r, input int base, input int n);
        for (int b = 0; b < n; b++) begin
            pkt_data[r].push_back(DW'(base + b));
            pkt_last[r].push_back(b == n - 1);
        end
    endtask

    // One clock cycle: drive at negedge, then monitor the write port and record handshakes.
    task automatic step(input bit r, input bit af, input bit full);
        @(negedge clk);
        cyc++;
        rst              = r;
        fifo_almost_full = af;
        fifo_full        = full;
        for (int i = 0; i < N; i++) begin
            if (pkt_data[i].size() > 0) begin
                req_valid[i]          = 1'b1;
                req_last[i]           = pkt_last[i][0];
                req_data[i*DW +: DW]  = pkt_data[i][0];
            end else begin
                req_valid[i]          = 1'b0;
                req_last[i]           = 1'b0;
                req_data[i*DW +: DW]  = '0;
            end
        end
        #1;
        last_acc = '0;
        if (fifo_wr_en === 1'b1) begin
            wr_cycles.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("spare_write", fifo_wr_en, 0);
            end else begin
                check("wr_data", fifo_data_in, exp_q.pop_front());
                if (acc_q.size() == 0) check("wr_without_accept", fifo_wr_en, 0);
                else check("wr_latency", cyc, acc_q.pop_front() + 1);
            end
        end
        if (full) check("wr_while_full", fifo_wr_en, 0);
        if (af || full) check("ready_throttled", req_ready, 0);
        if (!r) begin
            check("ready_onehot0", $onehot0(req_ready), 1);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    last_acc[i] = pkt_last[i][0];
                    void'(pkt_data[i].pop_front());
                    void'(pkt_last[i].pop_front());
                    acc_q.push_back(cyc);
                    acc_cnt[i]++;
                end
            end
        end
    endtask

    task automatic check_idle_state(input string tag);
        check({tag, "_wr_en"}, fifo_wr_en, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_grant_id"}, grant_id, 0);
        check({tag, "_ready"}, req_ready, 0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) begin
            pkt_data[i].delete();
            pkt_last[i].delete();
            acc_cnt[i] = 0;
        end
        exp_q.delete();
        acc_q.delete();
        step(1, 0, 0);
        step(0, 0, 0);
        check_idle_state("reset");
        check("reset_data", fifo_data_in, 0);
        wr_cycles.delete();
    endtask

    task automatic drain(input string tag, input int budget);
        int  k;
        bit  pending;
        k = 0;
        pending = 1'b1;
        while (pending && k < budget) begin
            pending = (exp_q.size() > 0);
            for (int i = 0; i < N; i++) if (pkt_data[i].size() > 0) pending = 1'b1;
            if (pending) step(0, 0, 0);
            k++;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic wait_acc(input int r, input int n, input int budget);
        int k;
        k = 0;
        while (acc_cnt[r] < n && k < budget) begin
            step(0, 0, 0);
            k++;
        end
        check("wait_acc", acc_cnt[r] >= n, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        fifo_full = 1'b0;
        fifo_almost_full = 1'b0;
        last_acc = '0;

        // Single requester, 3-beat packet.
        do_reset();
        load(0, 'hA, 3);
        exp_q.push_back('hA);
        exp_q.push_back('hB);
        exp_q.push_back('hC);
        step(0, 0, 0);
        check("t1_arb_busy", busy, 0);
        check("t1_arb_ready", req_ready, 0);
        step(0, 0, 0);
        check("t1_busy", busy, 1);
        check("t1_grant_id", grant_id, 0);
        check("t1_ready", req_ready, 4'b0001);
        for (int k = 0; k < 20 && !last_acc[0]; k++) step(0, 0, 0);
        step(0, 0, 0);
        check("t1_busy_drop", busy, 0);
        drain("t1", 20);
        check("t1_wr_count", wr_cycles.size(), 3);
        if (wr_cycles.size() == 3) check("t1_consecutive", wr_cycles[2] - wr_cycles[0], 2);

        // All requesters offering 1-beat packets continuously.
        do_reset();
        for (int r = 0; r < N; r++) begin
            load(r, r, 1);
            load(r, r, 1);
        end
        for (int k = 0; k < 2 * N; k++) exp_q.push_back(DW'(k % N));
        drain("t2", 60);
        check("t2_wr_count", wr_cycles.size(), 2 * N);
        for (int k = 0; k + 1 < wr_cycles.size(); k++)
            check("t2_bubble", wr_cycles[k+1] - wr_cycles[k], 2);

        // almost_full raised for 5 cycles after beat 2 of a 4-beat packet.
        do_reset();
        load(2, 'h20, 4);
        for (int b = 0; b < 4; b++) exp_q.push_back(DW'('h20 + b));
        wait_acc(2, 2, 20);
        for (int w = 0; w < 5; w++) step(0, 1, (w >= 1 && w <= 3));
        check("t3_held_acc", acc_cnt[2], 2);
        step(0, 0, 0);
        check("t3_ready_resume", req_ready[2], 1);
        drain("t3", 20);
        check("t3_wr_count", wr_cycles.size(), 4);

        // 10-beat packet on r0 versus 2-beat packet on r1.
        do_reset();
        load(0, 'h100, 10);
        load(1, 'h200, 2);
`ifdef ARB_BURST_LIMIT_EN
        for (int b = 0; b < 4; b++) exp_q.push_back(DW'('h100 + b));
        for (int b = 0; b < 2; b++) exp_q.push_back(DW'('h200 + b));
        for (int b = 4; b < 10; b++) exp_q.push_back(DW'('h100 + b));
`else
        for (int b = 0; b < 10; b++) exp_q.push_back(DW'('h100 + b));
        for (int b = 0; b < 2; b++) exp_q.push_back(DW'('h200 + b));
`endif
        drain("t4", 100);
        check("t4_wr_count", wr_cycles.size(), 12);

        // Reset on beat 3 of a 6-beat packet from r3.
        do_reset();
        load(3, 'h300, 6);
        exp_q.push_back('h300);
        exp_q.push_back('h301);
        wait_acc(3, 2, 20);
        step(1, 0, 0);
        pkt_data[3].delete();
        pkt_last[3].delete();
        step(0, 0, 0);
        check_idle_state("t6");
        load(1, 'h41, 1);
        load(3, 'h43, 1);
        exp_q.push_back('h41);
        exp_q.push_back('h43);
        drain("t6", 30);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin, packet-aware arbiter that shares one FIFO write port among NUM_REQ requesters. It sits in front of the write side of a FIFO, such as the AXI RAB command and response buffers, in the FIFO's write clock domain. A grant is held for a whole packet, so beats of different requesters never interleave in the FIFO. The write to the FIFO is registered, and throttling uses the FIFO's full and almost_full flags.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, ≥2.
- DW, 32: beat width.
- MAX_BURST, 16: maximum beats per grant, used only with ARB_BURST_LIMIT_EN.

Ports:
- clk  in  1: single clock, the FIFO write clock.
- rst  in  1: reset, synchronous and active-high.
- req_valid  in  NUM_REQ: per-requester beat valid.
- req_last  in  NUM_REQ: per-requester last beat of packet.
- req_data  in  NUM_REQ*DW: requester i occupies bits [i*DW +: DW].
- req_ready  out  NUM_REQ: one-hot or zero; beat accepted when valid & ready.
- fifo_wr_en  out  1: FIFO write strobe, registered.
- fifo_data_in  out  DW: FIFO write data, registered.
- fifo_full  in  1: FIFO full flag.
- fifo_almost_full  in  1: FIFO occupancy ≥ depth-1.
- grant_id  out  $clog2(NUM_REQ): current or last granted requester.
- busy  out  1: high while in GRANT.

## Operation
- FSM states: IDLE, GRANT.
- IDLE:
  - req_ready = 0.
  - If any req_valid is high, pick the first valid index searching upward from rr_ptr, with modulo wrap.
  - Register that index in grant_id, clear beat_cnt, and go to GRANT.
  - Requesters are not required to present last before being granted.
- GRANT:
  - req_ready[grant_id] = ~fifo_full & ~fifo_almost_full. All other ready bits are 0.
  - On an accepted beat: fifo_data_in <= that requester's data, fifo_wr_en <= 1, beat_cnt++.
  - With no accepted beat in a cycle, fifo_wr_en <= 0 and fifo_data_in holds its value.
  - On an accepted beat with req_last high: go to IDLE and set rr_ptr <= grant_id+1 (mod NUM_REQ).
- Requester deasserts valid mid-packet: the grant is held indefinitely; there is no timeout.
- Throttle rule: a beat is accepted only when ~fifo_almost_full. With one registered write in flight, this guarantees the FIFO never receives a write while full. fifo_full is also gated as a safety check.
- Width rules:
  - rr_ptr and grant_id are $clog2(NUM_REQ) bits.
  - Wrap is explicit: index NUM_REQ-1 goes to 0, including for NUM_REQ that is not a power of two.
  - beat_cnt is $clog2(MAX_BURST+1) bits.
- Reset values:
  - state = IDLE, rr_ptr = 0, grant_id = 0, beat_cnt = 0.
  - fifo_wr_en = 0, fifo_data_in = 0, busy = 0, req_ready = 0.
- Reset mid-packet: the packet is abandoned and any in-flight write is dropped (fifo_wr_en = 0 in the cycle after rst).

## Timing
- The arbitration decision in IDLE takes 1 cycle. Earliest req_ready is the cycle after the first req_valid is seen in IDLE.
- A beat accepted in cycle t appears as fifo_wr_en and fifo_data_in in cycle t+1.
- Sustained throughput: 1 beat per cycle while the FIFO is not almost full.
- Packet-to-packet gap: exactly 1 bubble cycle (the IDLE arbitration cycle).
- fifo_almost_full rising in cycle t: req_ready is low in cycle t itself (combinational), with at most 1 write already in flight.
- busy and grant_id change on the clock edge entering or leaving GRANT.

## Configuration
- ARB_BURST_LIMIT_EN defined:
  - When an accepted beat makes beat_cnt == MAX_BURST without req_last, the grant is released: go to IDLE and set rr_ptr <= grant_id+1.
  - The requester continues its packet after re-winning arbitration. Its packet is then interleaved with other requesters at MAX_BURST granularity, which is the consumer's responsibility.
- Undefined: the beat_cnt limit logic is absent and the grant is held until req_last.

## Test plan
- Requester 0 only, empty FIFO, 3-beat packet 0xA, 0xB, 0xC:
  - grant_id = 0.
  - fifo_wr_en high for 3 consecutive cycles with 0xA, 0xB, 0xC, each one cycle after acceptance.
  - busy drops the cycle after the 0xC beat is accepted.
- All 4 requesters continuously offering 1-beat packets (data = index):
  - FIFO receives 0, 1, 2, 3, 0, 1.
  - One bubble between each.
- Requester 2 sends a 4-beat packet and fifo_almost_full is raised for 5 cycles after beat 2:
  - req_ready[2] is low for exactly those cycles.
  - All 4 beats are written in order with no duplicates and no write while fifo_full.
- ARB_BURST_LIMIT_EN, MAX_BURST = 4; requester 0 has a 10-beat packet, requester 1 has a 2-beat packet:
  - FIFO order is r0 × 4, r1 × 2, r0 × 4, r0 × 2.
- Same stimulus without the macro:
  - FIFO order is r0 × 10, then r1 × 2.
- rst asserted on beat 3 of a 6-beat packet from requester 3:
  - Next cycle: fifo_wr_en = 0, busy = 0, grant_id = 0, req_ready = 0.
  - After release, requester 1 and requester 3 both valid → requester 1 is granted first (rr_ptr = 0).
